// File: rtl/tap_delay_line_seq_pkg.sv
// Shared constants, types and helpers for the tap delay line / phase sequencer.
//   DATA_W            default sample width (signed two's complement)
//   DEPTH             default number of taps
//   CYCLES_PER_SAMPLE default clocks per sample period
//   sample_t          signed sample type at the default width
//   npair(depth)      number of symmetric tap pairs, ceil(depth/2)
package tdl_pkg;

  localparam int unsigned DATA_W            = 10;
  localparam int unsigned DEPTH             = 119;
  localparam int unsigned CYCLES_PER_SAMPLE = 64;

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic int unsigned npair(input int unsigned depth);
    return (depth + 1) / 2;
  endfunction

endpackage

// File: rtl/tap_delay_line_seq_if.sv
// Sample input stream (valid/ready) for the tap delay line.
//   data   sample word
//   valid  data is valid (source -> sink)
//   ready  sink accepts data this cycle (sink -> source)
interface tap_delay_line_seq_if #(
  parameter int unsigned DATA_W = tdl_pkg::DATA_W
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/tap_delay_line_seq_hold_buf.sv
// One-entry holding buffer in front of the delay line, with bypass on the shift cycle.
//   clk_en, reset  clock and synchronous active-high reset
//   flush          synchronous clear; blocks acceptance this cycle
//   shift          current cycle is the shift cycle
//   in_data/in_valid/in_ready  input handshake
//   load_avail     a sample is available for tap[0] (meaningful on the shift cycle)
//   load_data      that sample: buffered word, else the bypassed input
module tdl_hold_buf #(
  parameter int unsigned DATA_W = tdl_pkg::DATA_W
) (
  input  logic              clk_en,
  input  logic              reset,
  input  logic              flush,
  input  logic              shift,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_avail,
  output logic [DATA_W-1:0] load_data
);

  logic              buf_full_q;
  logic [DATA_W-1:0] buf_data_q;
  logic              hs;

  // The shift cycle drains the buffer, so a full buffer can still accept then.
  assign in_ready   = !reset && !flush && (!buf_full_q || shift);
  assign hs         = in_valid && in_ready;
  assign load_avail = buf_full_q || hs;
  assign load_data  = buf_full_q ? buf_data_q : in_data;

  always_ff @(posedge clk_en) begin
    if (reset || flush) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else if (hs) begin
      buf_data_q <= in_data;
      // On the shift cycle an empty buffer bypasses instead of filling.
      buf_full_q <= buf_full_q || !shift;
    end else if (shift) begin
      buf_full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/tap_delay_line_seq.sv
// Shared sample delay line with integrated phase sequencer for the serial filter bank.
//   clk_en, reset     clock and synchronous active-high reset
//   flush             synchronous clear of taps, buffer, phase and underrun
//   in_if             sample input stream (slave)
//   taps              flattened taps, tap[k] at [k*DATA_W +: DATA_W], tap[0] newest
//   phase             phase within the sample period
//   frame_start       phase == 0
//   frame_last        phase == CYCLES_PER_SAMPLE-1 (taps shift at its closing edge)
//   tap_a, tap_b      symmetric tap pair (tap[p], tap[DEPTH-1-p]) for phase p < NPAIR
//   pair_valid        pair outputs valid
//   pair_last         last pair of the frame
//   underrun          sticky: a shift happened with no sample available
//   clear_underrun    clears underrun (a coincident empty shift wins)
module tap_delay_line_seq #(
  parameter int unsigned DATA_W            = tdl_pkg::DATA_W,
  parameter int unsigned DEPTH             = tdl_pkg::DEPTH,
  parameter int unsigned CYCLES_PER_SAMPLE = tdl_pkg::CYCLES_PER_SAMPLE,
  localparam int unsigned PW               = $clog2(CYCLES_PER_SAMPLE)
) (
  input  logic                    clk_en,
  input  logic                    reset,
  input  logic                    flush,
  tap_delay_line_seq_if.slave     in_if,
  output logic [DEPTH*DATA_W-1:0] taps,
  output logic [PW-1:0]           phase,
  output logic                    frame_start,
  output logic                    frame_last,
  output logic [DATA_W-1:0]       tap_a,
  output logic [DATA_W-1:0]       tap_b,
  output logic                    pair_valid,
  output logic                    pair_last,
  output logic                    underrun,
  input  logic                    clear_underrun
);
  import tdl_pkg::*;

  localparam int unsigned NPAIR = npair(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (CYCLES_PER_SAMPLE < NPAIR + 1) begin : g_bad_cps
    $error("CYCLES_PER_SAMPLE must be at least NPAIR+1");
  end

  typedef logic signed [DATA_W-1:0] smp_t;

  logic [PW-1:0]     phase_q;
  smp_t              tap_q [DEPTH];
  logic              underrun_q;
  logic              shift;
  logic              load_avail;
  logic [DATA_W-1:0] load_data;

  assign shift = (phase_q == PW'(CYCLES_PER_SAMPLE - 1));

  tdl_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk_en     (clk_en),
    .reset      (reset),
    .flush      (flush),
    .shift      (shift),
    .in_data    (in_if.data),
    .in_valid   (in_if.valid),
    .in_ready   (in_if.ready),
    .load_avail (load_avail),
    .load_data  (load_data)
  );

  always_ff @(posedge clk_en) begin
    if (reset || flush) begin
      phase_q    <= '0;
      underrun_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) tap_q[k] <= '0;
    end else begin
      phase_q <= shift ? '0 : phase_q + PW'(1);
      if (shift) begin
        tap_q[0] <= load_avail ? smp_t'(load_data) : '0;
        for (int k = 1; k < DEPTH; k++) tap_q[k] <= tap_q[k-1];
      end
      if (shift && !load_avail) underrun_q <= 1'b1;
      else if (clear_underrun)  underrun_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*DATA_W +: DATA_W] = tap_q[k];
  end

  assign phase       = phase_q;
  assign frame_start = (phase_q == '0);
  assign frame_last  = shift;
  assign underrun    = underrun_q;

  // Pair mux: decoded per phase so every tap index is a constant.
  always_comb begin
    pair_valid = 1'b0;
    pair_last  = 1'b0;
    tap_a      = '0;
    tap_b      = '0;
    for (int unsigned p = 0; p < NPAIR; p++) begin
      if (phase_q == PW'(p)) begin
        pair_valid = 1'b1;
        pair_last  = (p == NPAIR - 1);
        tap_a      = tap_q[p];
        // Odd DEPTH: the centre tap pairs with nothing.
        if (DEPTH - 1 - p != p) tap_b = tap_q[DEPTH-1-p];
      end
    end
  end

endmodule

// File: doc/tap_delay_line_seq.md
# tap_delay_line_seq

Parametrised shared sample delay line with an integrated phase sequencer, for the serial filter bank. Holds the last DEPTH input samples, advances exactly once per CYCLES_PER_SAMPLE clocks, and accepts input through a valid/ready handshake backed by a one-entry holding buffer. Streams symmetric tap pairs (tap[p], tap[DEPTH-1-p]) to serial MAC filters and generates the frame strobes those filters use. This replaces the gated-clock shift register and its externally supplied phase strobe.

## Interface
- DATA_W, 10: sample width, signed two's complement.
- DEPTH, 119: number of taps, 2 or more.
- CYCLES_PER_SAMPLE, 64: clocks per sample period. Must be at least NPAIR+1; a smaller value is an elaboration error.
- NPAIR (derived): ceil(DEPTH/2).
- clk_en  in  1  clock. All state updates on its rising edge; no internal clock gating.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of taps, buffer and phase.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- taps  out  DEPTH*DATA_W  flattened taps; tap[k] is at bits [k*DATA_W +: DATA_W], and tap[0] is the newest sample.
- phase  out  clog2(CYCLES_PER_SAMPLE)  current phase, 0..CYCLES_PER_SAMPLE-1.
- frame_start  out  1  high while phase==0.
- frame_last  out  1  high while phase==CYCLES_PER_SAMPLE-1; taps shift at the end of this cycle.
- tap_a, tap_b  out  DATA_W each  serial tap pair.
- pair_valid  out  1  tap_a/tap_b valid.
- pair_last  out  1  last pair of the frame.
- underrun  out  1  sticky: a shift occurred with no sample available.
- clear_underrun  in  1  clears underrun.

## Operation
- Phase counter:
  - increments every clock;
  - wraps from CYCLES_PER_SAMPLE-1 to 0;
  - the cycle with phase==CYCLES_PER_SAMPLE-1 is the shift cycle.
- Holding buffer:
  - One entry: buf_data, buf_full.
  - in_ready = !flush && (!buf_full || shift cycle).
  - A handshake (in_valid && in_ready) outside the shift cycle writes the buffer and sets buf_full.
- Shift cycle, at its closing edge:
  - tap[k] <= tap[k-1] for k=1..DEPTH-1.
  - tap[0] is loaded from one of three sources:
    - buf_data, if buf_full. A simultaneous handshake refills the buffer, so buf_full stays 1.
    - in_data, if buffer empty and handshake this cycle (bypass). buf_full stays 0.
    - Otherwise 0, and underrun is set.
- Pair stream (combinational from the phase and tap registers):
  - For phase p < NPAIR: pair_valid=1, tap_a=tap[p].
  - tap_b = tap[DEPTH-1-p], except tap_b=0 when DEPTH-1-p == p (centre tap of odd DEPTH).
  - pair_last=1 when p==NPAIR-1.
  - For p >= NPAIR: pair_valid=0, pair_last=0, tap_a=tap_b=0.
- Width rule: taps and pair outputs are stored and passed unmodified. No arithmetic is performed in this block.
- underrun:
  - set on an empty-shift;
  - cleared by clear_underrun, reset or flush;
  - if set and clear_underrun coincide, set wins.
- flush: at the next edge, all taps = 0, buffer emptied, phase = 0, underrun = 0. A sample offered during flush is not accepted (in_ready=0).
- Simultaneous reset and flush: reset result (identical state).

## Timing
- Reset state (cycle after reset deasserts):
  - taps all 0, phase 0, frame_start 1, frame_last 0;
  - in_ready 1 (0 while reset is high);
  - pair_valid 1, tap_a/tap_b 0, pair_last 0 (unless NPAIR==1);
  - underrun 0.
- Latency:
  - A sample accepted in phase q (q < CYCLES_PER_SAMPLE-1) appears on tap[0] in the phase-0 cycle following the next shift.
  - A bypassed sample appears on tap[0] in the very next cycle (phase 0).
- Tap stability: taps change only on the shift edge, so they are stable for a full frame from frame_start to frame_last.
- Pair timing: the pair stream for a frame is presented in phases 0..NPAIR-1 with zero-cycle latency from phase.
- Back-pressure: a full buffer holds in_ready low until the shift cycle. At most one sample is accepted per frame in steady state.
- Reset or flush mid-frame: the frame is aborted and the next frame restarts at phase 0.

## Structure
- Package tdl_pkg:
  - default constants DATA_W, DEPTH, CYCLES_PER_SAMPLE;
  - function npair(depth) returning ceil(depth/2);
  - sample_t typedef (logic signed [DATA_W-1:0]).
- Sub-module tdl_hold_buf: the one-entry holding buffer with bypass and in_ready logic. The top contains the phase counter, tap register array, pair mux and underrun flag.

## Test plan
- Reset, then in_valid held high with in_data=1,2,3,… (defaults) -> in_ready 1 initially. After reset, in_data is offered from phase 0, so sample 1 is buffered and sample 2 enters tap[0] only if offered when the buffer is empty. After 3 frames, tap[0..2] equal the 3 most recent shifted samples; frame_start period is 64 clocks.
- Single sample 0x1FF offered exactly at phase 63 with buffer empty -> bypass; tap[0]=0x1FF at the next cycle (phase 0); in_ready never deasserted.
- No input for one frame -> tap[0]=0 after the shift and underrun=1. With clear_underrun asserted on the same cycle as a second empty-shift, underrun remains 1.
- DEPTH=119 with taps loaded k -> tap[k] -> phase 0: tap_a=tap[0], tap_b=tap[118]; phase 59: tap_a=tap[59], tap_b=0, pair_last=1; phase 60: pair_valid=0.
- Buffer full at phase 10, in_valid held -> in_ready=0 from phase 11 to phase 62, in_ready=1 at phase 63, buffered sample shifts in and the new sample is captured.
- flush asserted at phase 30 with nonzero taps and a full buffer -> next cycle: taps 0, phase 0, buffer empty, underrun 0; a sample offered during flush is not accepted.
